tile_c_drain: RTL and testbench
===============================

Name: tile_c_drain

Overview:
- Output-side counterpart of tile_a: tile_a feeds A rows into TMUL_FP16_16_32; this block captures the 512-bit RowProduct rows that TMUL produces.
- Assembles 16 rows into a C tile (16x32 FP16).
- Streams completed tiles downstream row-by-row over a valid/ready handshake.
- Two-bank ping-pong, so TMUL can fill one tile while the previous tile drains.

Parameters:
- EW, 16, element width in bits (FP16).
- COLS, 32, elements per row; row width = EW*COLS = 512.
- ROWS, 16, rows per tile.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous abort; discards all partial and full tiles.
- row_valid  input  1  RowProduct row present.
- row_in  input  EW*COLS  RowProduct row; element l at bits [(l+1)*EW-1 : l*EW].
- row_ready  output  1  block can accept row_in this cycle.
- out_valid  output  1  out_row holds a valid C-tile row.
- out_ready  input  1  downstream accepts out_row.
- out_row  output  EW*COLS  C-tile row, same packing as row_in.
- out_idx  output  $clog2(ROWS)  row index of out_row within its tile.
- out_last  output  1  out_row is row ROWS-1 of its tile.
- tile_cnt  output  8  completed tiles drained, mod 256.

Behaviour:
- **Reset (rst=0, async):**
  - Both bank full flags = 0; wr_bank = rd_bank = 0; wr_row = rd_row = 0.
  - row_ready = 1 after release; out_valid = 0; out_row = 0; out_idx = 0; out_last = 0; tile_cnt = 0.
  - Bank storage is not reset; contents are don't-care until written.
- **Write side:**
  - row_ready = ~full[wr_bank], combinational from registered state.
  - Accept = row_valid & row_ready. On accept, row_in is stored at bank[wr_bank][wr_row] and wr_row increments.
  - On accept with wr_row = ROWS-1: full[wr_bank] <= 1, wr_row <= 0, wr_bank toggles.
  - row_valid with row_ready=0: row is not stored. The producer holds it.
- **Read side (per-bank state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY):**
  - out_valid = full[rd_bank].
  - out_row = bank[rd_bank][rd_row], registered so it is stable while out_valid=1.
  - out_idx = rd_row; out_last = out_valid & (rd_row = ROWS-1).
  - Transfer = out_valid & out_ready; rd_row increments on transfer.
  - Transfer with out_last: full[rd_bank] <= 0, rd_row <= 0, rd_bank toggles, tile_cnt += 1 (wraps 255 -> 0).
  - out_valid, once high, holds out_row, out_idx and out_last stable until transfer.
- **Latency:** the accept that completes a tile in cycle N gives out_valid=1 with out_idx=0 in cycle N+1, provided rd_bank equals that bank. Steady state is 1 row/cycle each side.
- **Both banks full:** row_ready = 0 until the drain of rd_bank completes. On that cycle full clears and row_ready = 1 on the next cycle; there is no combinational ready path from out_ready.
- **Simultaneous events:**
  - Completing fill of bank X and completing drain of bank Y (X != Y) in the same cycle: both take effect.
  - Write and read never target the same bank row in one cycle, because a bank being filled is never full.
- **clr:** has priority over all handshakes in that cycle. It:
  - clears both full flags, both pointers and both bank selects;
  - sets out_valid = 0 next cycle;
  - leaves tile_cnt unchanged.
  - A row offered in the clr cycle is dropped.
- **Reset mid-operation:** all in-flight data is lost. Outputs take reset values immediately (async).
- **Arithmetic:** pure storage, no FP arithmetic; bits pass through unmodified.

Decomposition:
- tmul_pkg holds:
  - localparams EW=16, COLS=32, ROWS=16;
  - typedef fp16_t (logic [15:0]);
  - typedef row_t (logic [EW*COLS-1:0]);
  - typedef bank_state_e {EMPTY, FILLING, FULL, DRAINING}.
- Sub-module tile_c_bank: one ROWSxrow_t storage array with one write port (we, waddr, wdata) and one registered read port (raddr, rdata). tile_c_drain instantiates it twice and holds all control.

Test Plan:
- **Reset release, idle:** rst low then high; no stimulus -> row_ready=1, out_valid=0, out_row=0, tile_cnt=0.
- **Single tile, always-ready sink:** 16 rows, row r filled with all elements 16'h3C00+r, row_valid held high, out_ready=1 -> out_valid rises the cycle after the 16th accept. out_idx runs 0..15 on consecutive cycles with out_row matching the input. out_last=1 only at idx 15; tile_cnt=1.
- **Backpressure / both full:** out_ready=0; push 32 random rows -> row_ready drops after accept 32 and the 33rd row is held. Then set out_ready=1 -> after 16 transfers row_ready=1 next cycle. Drained data equals tile 0 then tile 1 in order.
- **Ping-pong overlap:** continuous row_valid, out_ready toggling 1010... over 4 tiles -> no data loss or reordering; tile_cnt=4; row_ready never deasserts while a bank is free.
- **clr mid-fill:** accept 7 rows, assert clr one cycle alongside a row_valid row -> that row is dropped, out_valid stays 0. The next 16 rows form a tile whose out_idx 0 equals the first post-clr row.
- **Async reset mid-drain:** drop rst at out_idx=5, independent of clk -> out_valid=0 and tile_cnt=0 immediately. After release the block behaves as from power-up.

Source files
------------

// File: rtl/tmul_pkg.sv
// Shared types and sizing for the TMUL FP16 16x32 tile datapath.
// Row packing: element l occupies bits [(l+1)*EW-1 : l*EW].
package tmul_pkg;
    localparam int EW    = 16;
    localparam int COLS  = 32;
    localparam int ROWS  = 16;
    localparam int ROW_W = EW * COLS;
    localparam int IDX_W = $clog2(ROWS);

    typedef logic [15:0]      fp16_t;
    typedef logic [ROW_W-1:0] row_t;
    typedef logic [IDX_W-1:0] rowIdx_t;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

    localparam rowIdx_t LAST_ROW = rowIdx_t'(ROWS - 1);

    function automatic rowIdx_t nextRow(input rowIdx_t idx);
        return (idx == LAST_ROW) ? '0 : idx + rowIdx_t'(1);
    endfunction
endpackage

// File: rtl/tile_c_bank.sv
// One C-tile bank: ROWS x row_t storage, one write port and one registered read port.
// No reset on purpose so the array maps onto block RAM.
module tile_c_bank
    import tmul_pkg::*;
(
    input  logic    clk,
    input  logic    we,
    input  rowIdx_t waddr,
    input  row_t    wdata,
    input  rowIdx_t raddr,
    output row_t    rdata
);
    row_t mem [ROWS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/tile_c_drain.sv
// Captures TMUL RowProduct rows into a two-bank ping-pong C-tile buffer and
// streams each completed tile downstream row by row over valid/ready.
module tile_c_drain
    import tmul_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       row_valid,
    input  row_t       row_in,
    output logic       row_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output row_t       out_row,
    output rowIdx_t    out_idx,
    output logic       out_last,
    output logic [7:0] tile_cnt
);
    logic [1:0] full;
    logic       wrBankReg;
    logic       rdBankReg;
    rowIdx_t    wrRowReg;
    rowIdx_t    rdRowReg;
    rowIdx_t    rdRowNext;
    logic [7:0] tileCntReg;
    logic       accept;
    logic       transfer;
    row_t       rdData [2];

    assign row_ready = ~full[wrBankReg];
    assign out_valid = full[rdBankReg];
    assign accept    = row_valid & row_ready & ~clr;
    assign transfer  = out_valid & out_ready & ~clr;
    assign out_idx   = rdRowReg;
    assign out_last  = out_valid & (rdRowReg == LAST_ROW);
    assign out_row   = out_valid ? rdData[rdBankReg] : '0;
    assign tile_cnt  = tileCntReg;

    // Banks are read every cycle at the row that will be current next cycle,
    // so out_row is already valid the cycle a tile becomes full.
    always_comb begin
        rdRowNext = rdRowReg;
        if (clr) begin
            rdRowNext = '0;
        end else if (transfer) begin
            rdRowNext = nextRow(rdRowReg);
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            localparam logic SEL = (gi == 1);
            bank_state_e stateReg;
            bank_state_e stateNext;
            logic        isFull;
            logic        wrHit;
            logic        wrDone;
            logic        rdHit;
            logic        rdDone;

            assign wrHit  = accept & (wrBankReg == SEL);
            assign wrDone = wrHit & (wrRowReg == LAST_ROW);
            assign rdHit  = transfer & (rdBankReg == SEL);
            assign rdDone = rdHit & (rdRowReg == LAST_ROW);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    stateReg <= EMPTY;
                end else begin
                    stateReg <= stateNext;
                end
            end

            always_comb begin
                stateNext = stateReg;
                if (clr) begin
                    stateNext = EMPTY;
                end else begin
                    unique case (stateReg)
                        EMPTY:    stateNext = wrDone ? FULL : (wrHit ? FILLING : EMPTY);
                        FILLING:  stateNext = wrDone ? FULL : FILLING;
                        FULL:     stateNext = rdDone ? EMPTY : (rdHit ? DRAINING : FULL);
                        DRAINING: stateNext = rdDone ? EMPTY : DRAINING;
                        default:  stateNext = EMPTY;
                    endcase
                end
            end

            always_comb begin
                isFull = (stateReg == FULL) || (stateReg == DRAINING);
            end
            assign full[gi] = isFull;

            tile_c_bank uBank (
                .clk   (clk),
                .we    (wrHit),
                .waddr (wrRowReg),
                .wdata (row_in),
                .raddr (rdRowNext),
                .rdata (rdData[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrBankReg  <= 1'b0;
            rdBankReg  <= 1'b0;
            wrRowReg   <= '0;
            rdRowReg   <= '0;
            tileCntReg <= 8'd0;
        end else if (clr) begin
            wrBankReg <= 1'b0;
            rdBankReg <= 1'b0;
            wrRowReg  <= '0;
            rdRowReg  <= '0;
        end else begin
            if (accept) begin
                wrRowReg <= nextRow(wrRowReg);
                if (wrRowReg == LAST_ROW) begin
                    wrBankReg <= ~wrBankReg;
                end
            end
            rdRowReg <= rdRowNext;
            if (transfer && out_last) begin
                rdBankReg  <= ~rdBankReg;
                tileCntReg <= tileCntReg + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_tile_c_drain.sv
// Bench for tile_c_drain: queue-based tile model checked every cycle, plus
// literal expectations at key points of each directed scenario.
module tb_tile_c_drain;
    import tmul_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       row_valid;
    row_t       row_in;
    logic       row_ready;
    logic       out_valid;
    logic       out_ready;
    row_t       out_row;
    rowIdx_t    out_idx;
    logic       out_last;
    logic [7:0] tile_cnt;

    always #5 clk = ~clk;

    tile_c_drain dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .row_valid (row_valid),
        .row_in    (row_in),
        .row_ready (row_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .tile_cnt  (tile_cnt)
    );

    int   vecs = 0;
    int   mis  = 0;
    row_t srcQ [$];
    int   sinkMode = 0;
    bit   chkEn = 0;

    // Model: completed tiles waiting downstream, rows of the tile being filled.
    int         mHeld;
    int         mDrainIdx;
    row_t       mExpQ [$];
    row_t       mFill [$];
    logic [7:0] mTcnt;
    bit         mConsumed;
    bit         mAcc;
    bit         mXfer;

    task automatic chkN(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkRow(input string nm, input row_t act, input row_t exp);
        vecs++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic modelReset();
        mHeld = 0;
        mDrainIdx = 0;
        mExpQ.delete();
        mFill.delete();
        mTcnt = 8'd0;
        mConsumed = 1'b0;
    endtask

    always @(negedge rst) modelReset();

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            mAcc = row_valid && (mHeld < 2) && !clr;
            mXfer = (mHeld > 0) && out_ready && !clr;
            mConsumed = row_valid && (mAcc || clr);
            if (clr) begin
                mHeld = 0;
                mDrainIdx = 0;
                mExpQ.delete();
                mFill.delete();
            end else begin
                if (mXfer) begin
                    mDrainIdx++;
                    if (mDrainIdx == ROWS) begin
                        mDrainIdx = 0;
                        mHeld--;
                        repeat (ROWS) void'(mExpQ.pop_front());
                        mTcnt = mTcnt + 8'd1;
                    end
                end
                if (mAcc) begin
                    mFill.push_back(row_in);
                    if (mFill.size() == ROWS) begin
                        foreach (mFill[k]) mExpQ.push_back(mFill[k]);
                        mFill.delete();
                        mHeld++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1 && chkEn) begin
            chkN("row_ready", 32'(row_ready), 32'(mHeld < 2));
            chkN("out_valid", 32'(out_valid), 32'(mHeld > 0));
            chkN("tile_cnt", 32'(tile_cnt), 32'(mTcnt));
            if (mHeld > 0) begin
                chkN("out_idx", 32'(out_idx), 32'(mDrainIdx));
                chkN("out_last", 32'(out_last), 32'(mDrainIdx == ROWS - 1));
                chkRow("out_row", out_row, mExpQ[mDrainIdx]);
                if (out_ready && !clr)
                    $display("drain tile=%0d idx=%0d data[15:0]=%h", mTcnt, mDrainIdx, out_row[15:0]);
            end
        end
    end

    task automatic drive();
        row_valid = (srcQ.size() > 0);
        row_in = row_valid ? srcQ[0] : '0;
        case (sinkMode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ~out_ready;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (mConsumed && srcQ.size() > 0) void'(srcQ.pop_front());
        drive();
    endtask

    task automatic waitSrcEmpty(input string nm, input int budget);
        for (int i = 0; i < budget && srcQ.size() > 0; i++) tick();
        chkN(nm, 32'(srcQ.size()), 32'd0);
    endtask

    task automatic waitTiles(input string nm, input int target, input int budget);
        for (int i = 0; i < budget && mTcnt != 8'(target); i++) tick();
        chkN(nm, 32'(tile_cnt), 32'(target));
    endtask

    function automatic row_t randRow();
        row_t r;
        for (int k = 0; k < ROW_W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic row_t fillRow(input logic [15:0] v);
        row_t r;
        for (int l = 0; l < COLS; l++) r[l*EW +: EW] = v;
        return r;
    endfunction

    row_t expRow;
    row_t firstRow;

    initial begin
        rst = 1'b0;
        clr = 1'b0;
        row_valid = 1'b0;
        row_in = '0;
        out_ready = 1'b0;
        modelReset();
        #12 rst = 1'b1;
        tick();
        tick();
        chkEn = 1'b1;

        // Reset release, idle
        chkN("idle_row_ready", 32'(row_ready), 32'd1);
        chkN("idle_out_valid", 32'(out_valid), 32'd0);
        chkRow("idle_out_row", out_row, '0);
        chkN("idle_tile_cnt", 32'(tile_cnt), 32'd0);
        chkN("idle_out_last", 32'(out_last), 32'd0);

        // Single tile, always-ready sink
        sinkMode = 1;
        for (int r = 0; r < ROWS; r++) srcQ.push_back(fillRow(16'h3C00 + 16'(r)));
        drive();
        waitSrcEmpty("t1_fill_timeout", 40);
        expRow = {32{16'h3C00}};
        chkN("t1_valid_after_last_accept", 32'(out_valid), 32'd1);
        chkN("t1_first_idx", 32'(out_idx), 32'd0);
        chkRow("t1_first_row", out_row, expRow);
        chkN("t1_first_not_last", 32'(out_last), 32'd0);
        chkN("t1_cnt_before_drain", 32'(tile_cnt), 32'd0);
        for (int i = 0; i < 30 && !(out_valid && out_last); i++) tick();
        expRow = {32{16'h3C0F}};
        chkN("t1_last_idx", 32'(out_idx), 32'd15);
        chkRow("t1_last_row", out_row, expRow);
        waitTiles("t1_tile_cnt", 1, 20);

        // Backpressure until both banks are full
        sinkMode = 0;
        for (int r = 0; r < 2 * ROWS + 1; r++) srcQ.push_back(randRow());
        drive();
        for (int i = 0; i < 100 && srcQ.size() > 1; i++) tick();
        tick();
        tick();
        chkN("t2_both_full_ready", 32'(row_ready), 32'd0);
        chkN("t2_both_full_valid", 32'(out_valid), 32'd1);
        chkN("t2_held_row_count", 32'(srcQ.size()), 32'd1);
        sinkMode = 1;
        drive();
        waitTiles("t2_first_drain", 2, 40);
        chkN("t2_ready_after_drain", 32'(row_ready), 32'd1);
        waitTiles("t2_second_drain", 3, 40);

        // Ping-pong overlap with a half-rate sink
        sinkMode = 2;
        for (int r = 0; r < 4 * ROWS - 1; r++) srcQ.push_back(randRow());
        drive();
        waitTiles("t3_tile_cnt", 7, 500);

        // clr mid-fill drops the partial tile and the row offered alongside it
        sinkMode = 1;
        for (int r = 0; r < 7; r++) srcQ.push_back(randRow());
        drive();
        waitSrcEmpty("t4_prefill_timeout", 30);
        clr = 1'b1;
        srcQ.push_back(randRow());
        drive();
        tick();
        clr = 1'b0;
        chkN("t4_clr_out_valid", 32'(out_valid), 32'd0);
        chkN("t4_clr_row_ready", 32'(row_ready), 32'd1);
        chkN("t4_clr_tile_cnt", 32'(tile_cnt), 32'd7);
        firstRow = randRow();
        srcQ.push_back(firstRow);
        for (int r = 1; r < ROWS; r++) srcQ.push_back(randRow());
        drive();
        waitSrcEmpty("t4_fill_timeout", 40);
        chkN("t4_post_clr_valid", 32'(out_valid), 32'd1);
        chkN("t4_post_clr_idx", 32'(out_idx), 32'd0);
        chkRow("t4_post_clr_row0", out_row, firstRow);
        waitTiles("t4_tile_cnt", 8, 40);

        // Async reset in the middle of a drain
        for (int r = 0; r < ROWS; r++) srcQ.push_back(randRow());
        drive();
        for (int i = 0; i < 60 && !(mHeld > 0 && mDrainIdx == 5); i++) tick();
        chkN("t5_pre_reset_idx", 32'(out_idx), 32'd5);
        #3 rst = 1'b0;
        #1;
        chkN("t5_reset_out_valid", 32'(out_valid), 32'd0);
        chkN("t5_reset_tile_cnt", 32'(tile_cnt), 32'd0);
        chkRow("t5_reset_out_row", out_row, '0);
        chkN("t5_reset_row_ready", 32'(row_ready), 32'd1);
        srcQ.delete();
        drive();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();
        chkN("t5_release_out_valid", 32'(out_valid), 32'd0);
        chkN("t5_release_tile_cnt", 32'(tile_cnt), 32'd0);
        for (int r = 0; r < ROWS; r++) srcQ.push_back(fillRow(16'h4000 + 16'(r)));
        drive();
        waitSrcEmpty("t5_fill_timeout", 40);
        expRow = {32{16'h4000}};
        chkRow("t5_first_row", out_row, expRow);
        waitTiles("t5_tile_cnt", 1, 40);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vecs);
        $fatal(1, "watchdog");
    end
endmodule
